// File: rtl/ssd1306_spi_rx_if.sv
// Pin-level 4-wire SPI link from the OLED sequencer (master) to the panel receiver (slave).
// oled_cs_n exists only when SSD1306_RX_CS_EN is defined.
interface ssd1306_spi_rx_if;
   logic oled_sclk;
   logic oled_sdin;
   logic oled_dc;
   logic oled_res;
`ifdef SSD1306_RX_CS_EN
   logic oled_cs_n;

   modport master (output oled_sclk, output oled_sdin, output oled_dc, output oled_res, output oled_cs_n);
   modport slave  (input  oled_sclk, input  oled_sdin, input  oled_dc, input  oled_res, input  oled_cs_n);
`else
   modport master (output oled_sclk, output oled_sdin, output oled_dc, output oled_res);
   modport slave  (input  oled_sclk, input  oled_sdin, input  oled_dc, input  oled_res);
`endif
endinterface

// File: rtl/ssd1306_spi_rx.sv
// SSD1306-compatible SPI receiver: oversamples the link, assembles mode-0 bytes, decodes commands, emits GDDRAM writes.
// Optional chip-select framing is enabled with SSD1306_RX_CS_EN.
module ssd1306_spi_rx #(
   parameter int         SYNC_STAGES  = 2,
   parameter logic [7:0] CONTRAST_RST = 8'h7F
) (
   input  logic                 clk_50M,
   input  logic                 rst_n,
   ssd1306_spi_rx_if.slave      spi,
   output logic                 byte_valid,
   output logic [7:0]           byte_data,
   output logic                 byte_is_data,
   output logic                 disp_on,
   output logic                 all_on,
   output logic                 invert,
   output logic [7:0]           contrast,
   output logic                 charge_pump,
   output logic [1:0]           mem_mode,
   output logic                 ram_we,
   output logic [9:0]           ram_addr,
   output logic [7:0]           ram_wdata,
   output logic                 cmd_err
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ARG1 = 2'd1;
   localparam logic [1:0] S_ARG2 = 2'd2;

   // Synchroniser lanes: 0 sclk, 1 sdin, 2 dc, 3 res, (4 cs_n). res starts low so the panel stays in reset briefly.
`ifdef SSD1306_RX_CS_EN
   localparam int NSIG = 5;
   localparam logic [NSIG-1:0] SYNC_RST = 5'b10000;
   logic [NSIG-1:0] raw_pins;
   assign raw_pins = {spi.oled_cs_n, spi.oled_res, spi.oled_dc, spi.oled_sdin, spi.oled_sclk};
`else
   localparam int NSIG = 4;
   localparam logic [NSIG-1:0] SYNC_RST = 4'b0000;
   logic [NSIG-1:0] raw_pins;
   assign raw_pins = {spi.oled_res, spi.oled_dc, spi.oled_sdin, spi.oled_sclk};
`endif

   logic [NSIG-1:0] synced;

   genvar gi;
   generate
      for (gi = 0; gi < NSIG; gi++) begin : g_sync
         logic [SYNC_STAGES-1:0] sr_reg;
         always_ff @(posedge clk_50M or negedge rst_n) begin
            if (!rst_n) sr_reg <= {SYNC_STAGES{SYNC_RST[gi]}};
            else        sr_reg <= {sr_reg[SYNC_STAGES-2:0], raw_pins[gi]};
         end
         assign synced[gi] = sr_reg[SYNC_STAGES-1];
      end
   endgenerate

   logic sclk_s, sdin_s, dc_s, res_s, sclk_prev_reg, sclk_rise, selected, cs_rise;
   assign sclk_s = synced[0];
   assign sdin_s = synced[1];
   assign dc_s   = synced[2];
   assign res_s  = synced[3];
   assign sclk_rise = sclk_s & ~sclk_prev_reg;

`ifdef SSD1306_RX_CS_EN
   logic cs_prev_reg;
   assign selected = ~synced[4];
   assign cs_rise  = synced[4] & ~cs_prev_reg;
   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) cs_prev_reg <= 1'b1;
      else        cs_prev_reg <= synced[4];
   end
`else
   assign selected = 1'b1;
   assign cs_rise  = 1'b0;
`endif

   // Edge history keeps tracking through panel reset so no false edge appears on release.
   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) sclk_prev_reg <= 1'b0;
      else        sclk_prev_reg <= sclk_s;
   end

   typedef struct packed {
      logic       byte_valid;
      logic [7:0] byte_data;
      logic       byte_is_data;
      logic       disp_on;
      logic       all_on;
      logic       invert;
      logic [7:0] contrast;
      logic       charge_pump;
      logic [1:0] mem_mode;
      logic       ram_we;
      logic [9:0] ram_addr;
      logic [7:0] ram_wdata;
      logic       cmd_err;
      logic [1:0] fsm;
      logic [7:0] opcode;
      logic [6:0] col;
      logic [6:0] col_start;
      logic [6:0] col_end;
      logic [2:0] page;
      logic [2:0] page_start;
      logic [2:0] page_end;
      logic [2:0] bit_cnt;
      logic [6:0] shift;
   } rx_state_t;

   localparam rx_state_t RX_RST = '{contrast: CONTRAST_RST, mem_mode: 2'b10, col_end: 7'd127,
                                    page_end: 3'd7, default: '0};

   rx_state_t st_reg, st_next;
   logic [7:0] rx_byte;

   always_comb begin
      st_next            = st_reg;
      st_next.byte_valid = 1'b0;
      st_next.ram_we     = 1'b0;
      st_next.cmd_err    = 1'b0;
      rx_byte            = {st_reg.shift, sdin_s};
      if (cs_rise) begin
         st_next.bit_cnt = 3'd0;
      end else if (sclk_rise && selected) begin
         st_next.shift   = rx_byte[6:0];
         st_next.bit_cnt = st_reg.bit_cnt + 3'd1;
         if (st_reg.bit_cnt == 3'd7) begin
            st_next.byte_valid   = 1'b1;
            st_next.byte_data    = rx_byte;
            st_next.byte_is_data = dc_s;
            if (dc_s) begin
               // A data byte always lands in RAM, even when it aborts a pending command.
               st_next.ram_we    = 1'b1;
               st_next.ram_addr  = {st_reg.page, st_reg.col};
               st_next.ram_wdata = rx_byte;
               if (st_reg.fsm != S_IDLE) begin
                  st_next.cmd_err = 1'b1;
                  st_next.fsm     = S_IDLE;
               end
               case (st_reg.mem_mode)
                  2'b00: begin
                     if (st_reg.col == st_reg.col_end) begin
                        st_next.col  = st_reg.col_start;
                        st_next.page = (st_reg.page == st_reg.page_end) ? st_reg.page_start
                                                                        : st_reg.page + 3'd1;
                     end else begin
                        st_next.col = st_reg.col + 7'd1;
                     end
                  end
                  2'b01: begin
                     if (st_reg.page == st_reg.page_end) begin
                        st_next.page = st_reg.page_start;
                        st_next.col  = (st_reg.col == st_reg.col_end) ? st_reg.col_start
                                                                      : st_reg.col + 7'd1;
                     end else begin
                        st_next.page = st_reg.page + 3'd1;
                     end
                  end
                  default: begin
                     st_next.col = (st_reg.col == st_reg.col_end) ? st_reg.col_start
                                                                  : st_reg.col + 7'd1;
                  end
               endcase
            end else begin
               case (st_reg.fsm)
                  S_IDLE: begin
                     case (rx_byte) inside
                        8'hAE, 8'hAF: st_next.disp_on = rx_byte[0];
                        8'hA4, 8'hA5: st_next.all_on  = rx_byte[0];
                        8'hA6, 8'hA7: st_next.invert  = rx_byte[0];
                        8'h81, 8'h8D, 8'h20, 8'h21, 8'h22, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB: begin
                           st_next.fsm    = S_ARG1;
                           st_next.opcode = rx_byte;
                        end
                        8'hA0, 8'hA1, 8'hC0, 8'hC8, 8'hE3, [8'h40:8'h7F]: begin
                        end
                        [8'h00:8'h0F]: st_next.col[3:0] = rx_byte[3:0];
                        [8'h10:8'h17]: st_next.col[6:4] = rx_byte[2:0];
                        [8'hB0:8'hB7]: st_next.page     = rx_byte[2:0];
                        default:       st_next.cmd_err  = 1'b1;
                     endcase
                  end
                  S_ARG1: begin
                     st_next.fsm = S_IDLE;
                     case (st_reg.opcode)
                        8'h81: st_next.contrast    = rx_byte;
                        8'h8D: st_next.charge_pump = rx_byte[2];
                        8'h20: if (rx_byte[1:0] != 2'b11) st_next.mem_mode = rx_byte[1:0];
                        8'h21: begin
                           st_next.col_start = rx_byte[6:0];
                           st_next.fsm       = S_ARG2;
                        end
                        8'h22: begin
                           st_next.page_start = rx_byte[2:0];
                           st_next.fsm        = S_ARG2;
                        end
                        default: begin
                        end
                     endcase
                  end
                  S_ARG2: begin
                     st_next.fsm = S_IDLE;
                     if (st_reg.opcode == 8'h21) begin
                        st_next.col_end = rx_byte[6:0];
                        st_next.col     = st_reg.col_start;
                     end else begin
                        st_next.page_end = rx_byte[2:0];
                        st_next.page     = st_reg.page_start;
                     end
                  end
                  default: st_next.fsm = S_IDLE;
               endcase
            end
         end
      end
   end

   // Panel reset (synchronised oled_res low) takes priority over any concurrent sclk edge.
   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n)      st_reg <= RX_RST;
      else if (!res_s) st_reg <= RX_RST;
      else             st_reg <= st_next;
   end

   assign byte_valid   = st_reg.byte_valid;
   assign byte_data    = st_reg.byte_data;
   assign byte_is_data = st_reg.byte_is_data;
   assign disp_on      = st_reg.disp_on;
   assign all_on       = st_reg.all_on;
   assign invert       = st_reg.invert;
   assign contrast     = st_reg.contrast;
   assign charge_pump  = st_reg.charge_pump;
   assign mem_mode     = st_reg.mem_mode;
   assign ram_we       = st_reg.ram_we;
   assign ram_addr     = st_reg.ram_addr;
   assign ram_wdata    = st_reg.ram_wdata;
   assign cmd_err      = st_reg.cmd_err;
endmodule

// File: tb/tb_ssd1306_spi_rx.sv
// Bench for ssd1306_spi_rx: directed and random SPI byte streams checked against a command-level panel model.
module tb_ssd1306_spi_rx;
   logic clk_50M = 1'b0;
   logic rst_n   = 1'b0;
   always #10 clk_50M = ~clk_50M;

   ssd1306_spi_rx_if spi ();

   logic       byte_valid, byte_is_data, disp_on, all_on, invert, charge_pump, ram_we, cmd_err;
   logic [7:0] byte_data, contrast, ram_wdata;
   logic [1:0] mem_mode;
   logic [9:0] ram_addr;

   ssd1306_spi_rx dut (
      .clk_50M(clk_50M), .rst_n(rst_n), .spi(spi.slave),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_is_data(byte_is_data),
      .disp_on(disp_on), .all_on(all_on), .invert(invert), .contrast(contrast),
      .charge_pump(charge_pump), .mem_mode(mem_mode), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .cmd_err(cmd_err)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Observed strobes, sampled on the falling edge.
   logic [8:0]  bv_q[$];
   logic [17:0] we_q[$];
   int          err_seen;
   always @(negedge clk_50M) begin
      if (byte_valid) bv_q.push_back({byte_is_data, byte_data});
      if (ram_we)     we_q.push_back({ram_addr, ram_wdata});
      if (cmd_err)    err_seen++;
   end

   // Panel model: commands collect in a queue until their argument count is satisfied.
   logic       m_disp, m_all, m_inv, m_cp;
   logic [7:0] m_contrast;
   logic [1:0] m_mode;
   int         m_col, m_page, m_cs, m_ce, m_ps, m_pe;
   logic [7:0] cmd_q[$];

   task automatic model_reset();
      m_disp = 0; m_all = 0; m_inv = 0; m_cp = 0; m_contrast = 8'h7F; m_mode = 2'b10;
      m_col = 0; m_page = 0; m_cs = 0; m_ce = 127; m_ps = 0; m_pe = 7;
      cmd_q.delete();
   endtask

   function automatic int argc(input logic [7:0] op);
      if (op inside {8'h81, 8'h8D, 8'h20, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB}) return 1;
      if (op inside {8'h21, 8'h22}) return 2;
      if (op inside {8'hAE, 8'hAF, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA0, 8'hA1, 8'hC0, 8'hC8, 8'hE3,
                     [8'h40:8'h7F], [8'h00:8'h17], [8'hB0:8'hB7]}) return 0;
      return -1;
   endfunction

   task automatic model_byte(input logic dc, input logic [7:0] b,
                             output int exp_we, output logic [17:0] exp_w, output int exp_err);
      int n;
      exp_we = 0; exp_w = '0; exp_err = 0;
      if (dc) begin
         exp_we = 1;
         exp_w  = {10'(m_page * 128 + m_col), b};
         if (cmd_q.size() != 0) begin exp_err = 1; cmd_q.delete(); end
         if (m_mode == 2'b01) begin
            if (m_page == m_pe) begin
               m_page = m_ps;
               m_col  = (m_col == m_ce) ? m_cs : (m_col + 1) % 128;
            end else m_page = (m_page + 1) % 8;
         end else if (m_col == m_ce) begin
            m_col = m_cs;
            if (m_mode == 2'b00) m_page = (m_page == m_pe) ? m_ps : (m_page + 1) % 8;
         end else m_col = (m_col + 1) % 128;
      end else if (cmd_q.size() == 0) begin
         n = argc(b);
         if (n < 0) exp_err = 1;
         else if (n > 0) cmd_q.push_back(b);
         else if (b == 8'hAE || b == 8'hAF) m_disp = b[0];
         else if (b == 8'hA4 || b == 8'hA5) m_all = b[0];
         else if (b == 8'hA6 || b == 8'hA7) m_inv = b[0];
         else if (b <= 8'h0F) m_col = (m_col / 16) * 16 + int'(b % 16);
         else if (b <= 8'h17) m_col = (m_col % 16) + int'(b - 8'h10) * 16;
         else if (b >= 8'hB0 && b <= 8'hB7) m_page = int'(b - 8'hB0);
      end else begin
         cmd_q.push_back(b);
         n = cmd_q.size() - 1;
         case (cmd_q[0])
            8'h81: m_contrast = b;
            8'h8D: m_cp = b[2];
            8'h20: if (b % 4 != 3) m_mode = b[1:0];
            8'h21: if (n == 1) m_cs = b % 128; else begin m_ce = b % 128; m_col = m_cs; end
            8'h22: if (n == 1) m_ps = b % 8;   else begin m_pe = b % 8;   m_page = m_ps; end
            default: ;
         endcase
         if (n == argc(cmd_q[0])) cmd_q.delete();
      end
   endtask

   int half = 4;

   task automatic send_bits(input logic dc, input logic [7:0] b, input int nbits);
      for (int i = 7; i > 7 - nbits; i--) begin
         spi.oled_dc   = dc;
         spi.oled_sdin = b[i];
         repeat (half) @(posedge clk_50M);
         spi.oled_sclk = 1'b1;
         repeat (half) @(posedge clk_50M);
         spi.oled_sclk = 1'b0;
      end
      repeat (6) @(posedge clk_50M);
   endtask

   task automatic clear_obs();
      bv_q.delete(); we_q.delete(); err_seen = 0;
   endtask

   int xfer_n = 0;

   task automatic xfer(input logic dc, input logic [7:0] b);
      int         exp_we, exp_err;
      logic [17:0] exp_w;
      clear_obs();
      model_byte(dc, b, exp_we, exp_w, exp_err);
      send_bits(dc, b, 8);
      xfer_n++;
      check($sformatf("bv_cnt#%0d", xfer_n), bv_q.size(), 1);
      if (bv_q.size() > 0) check($sformatf("bv_byte#%0d", xfer_n), bv_q[0], {dc, b});
      check($sformatf("we_cnt#%0d", xfer_n), we_q.size(), exp_we);
      if (exp_we != 0 && we_q.size() > 0) check($sformatf("we_word#%0d", xfer_n), we_q[0], exp_w);
      check($sformatf("cmd_err#%0d", xfer_n), err_seen, exp_err);
      check($sformatf("regs#%0d", xfer_n), {disp_on, all_on, invert, contrast, charge_pump, mem_mode},
            {m_disp, m_all, m_inv, m_contrast, m_cp, m_mode});
   endtask

   logic [7:0] op_tab [0:21] = '{8'hAE, 8'hAF, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'h81, 8'h8D, 8'h20, 8'h21,
                                 8'h22, 8'hB2, 8'hB7, 8'h03, 8'h15, 8'hE3, 8'hC8, 8'h5A, 8'hD5, 8'hFF,
                                 8'h2F, 8'hA1};

   initial begin
      spi.oled_sclk = 1'b0; spi.oled_sdin = 1'b0; spi.oled_dc = 1'b0; spi.oled_res = 1'b1;
`ifdef SSD1306_RX_CS_EN
      spi.oled_cs_n = 1'b0;
`endif
      model_reset();
      clear_obs();
      repeat (5) @(posedge clk_50M);
      rst_n = 1'b1;
      repeat (6) @(posedge clk_50M);
      @(negedge clk_50M);
      check("rst_strobes", {byte_valid, ram_we, cmd_err}, 3'b000);
      check("rst_byte", {byte_is_data, byte_data}, 9'h000);
      check("rst_regs", {disp_on, all_on, invert, contrast, charge_pump, mem_mode}, {3'b000, 8'h7F, 1'b0, 2'b10});

      xfer(0, 8'hAF);
      check("disp_on_af", disp_on, 1'b1);
      xfer(0, 8'h81);
      check("contrast_hold", contrast, 8'h7F);
      xfer(0, 8'h3C);
      check("contrast_set", contrast, 8'h3C);

      xfer(0, 8'h20); xfer(0, 8'h00);
      xfer(0, 8'h21); xfer(0, 8'h7E); xfer(0, 8'h7F);
      xfer(0, 8'h22); xfer(0, 8'h00); xfer(0, 8'h01);
      for (int i = 1; i <= 5; i++) xfer(1, 8'(i * 8'h11));

      // Back to page mode with full windows, then positioned page-mode writes.
      xfer(0, 8'h20); xfer(0, 8'h02);
      xfer(0, 8'h21); xfer(0, 8'h00); xfer(0, 8'h7F);
      xfer(0, 8'h22); xfer(0, 8'h00); xfer(0, 8'h07);
      xfer(0, 8'hB3); xfer(0, 8'h05); xfer(0, 8'h12);
      xfer(1, 8'hAA);
      xfer(1, 8'h3D);

      // Panel reset mid-byte discards the partial byte and restores defaults.
      clear_obs();
      send_bits(0, 8'hFF, 5);
      spi.oled_res = 1'b0;
      repeat (6) @(posedge clk_50M);
      spi.oled_res = 1'b1;
      repeat (6) @(posedge clk_50M);
      model_reset();
      check("res_no_bv", bv_q.size(), 0);
      check("res_contrast", contrast, 8'h7F);
      xfer(0, 8'hA7);
      check("res_invert", invert, 1'b1);

      xfer(0, 8'h81);
      xfer(1, 8'h55);
      xfer(0, 8'hFF);

`ifdef SSD1306_RX_CS_EN
      xfer(0, 8'hAE);
      clear_obs();
      spi.oled_cs_n = 1'b1;
      send_bits(0, 8'hAF, 8);
      check("cs_no_bv", bv_q.size(), 0);
      check("cs_disp_hold", disp_on, 1'b0);
      spi.oled_cs_n = 1'b0;
      repeat (6) @(posedge clk_50M);
      send_bits(0, 8'hFF, 3);
      spi.oled_cs_n = 1'b1;
      repeat (6) @(posedge clk_50M);
      spi.oled_cs_n = 1'b0;
      repeat (6) @(posedge clk_50M);
      check("cs_partial_bv", bv_q.size(), 0);
      xfer(0, 8'hAF);
      check("cs_disp_on", disp_on, 1'b1);
`endif

      // Random mix of commands, arguments and data with varying sclk phase lengths.
      for (int k = 0; k < 160; k++) begin
         int kind;
         half = $urandom_range(3, 5);
         kind = $urandom_range(0, 9);
         if (kind < 4)      xfer(1, 8'($urandom));
         else if (kind < 9) xfer(0, op_tab[$urandom_range(0, 21)]);
         else               xfer(0, 8'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
